// File: rtl/arith_sched.sv
// arith_sched: round-robin scheduler in front of one shared signed
// add/sub/multiply datapath. One operation is in flight at a time; its result
// comes back on a single response channel tagged with the requester index and
// is held until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid                      [NREQ]
//   req_ready  per-requester accept, one-hot or zero (comb.)    [NREQ]
//   req_op     per-requester opcode, slice i = [2i+1:2i]        [2*NREQ]
//              00 add, 01 sub, 10 mul, 11 reserved (error response)
//   req_a      per-requester operand A, slice i = [W*i+W-1:W*i] [W*NREQ]
//   req_b      per-requester operand B, same slicing            [W*NREQ]
//   rsp_valid  response valid (registered)
//   rsp_ready  response accept
//   rsp_id     index of the requester that issued the op        [IDW]
//   rsp_data   signed result, sign-extended to 2W bits          [2W]
//   rsp_err    reserved opcode seen; rsp_data is zero
module arith_sched #(
  parameter int NREQ    = 2,
  parameter int W       = 17,
  parameter int MUL_LAT = 2,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_a,
  input  logic [W*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_data,
  output logic                rsp_err
);

  // Counter only has to hold MUL_LAT-1.
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int RW = 2 * W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found_s;
  logic            gnt_hit_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic [1:0]      gnt_op_s;
  logic [W-1:0]    gnt_a_s;
  logic [W-1:0]    gnt_b_s;
  logic [RW-1:0]   a_ext_s;
  logic [RW-1:0]   b_ext_s;
  logic [RW-1:0]   res_s;
  logic            res_err_s;

  // (base + off) mod NREQ, for base < NREQ and off <= NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
    int unsigned s;
    s = {{(32-IDW){1'b0}}, base} + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return s[IDW-1:0];
  endfunction

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_hit_s   = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      gnt_hit_s   = ~gnt_found_s & req_valid[rr_index(ptr_q, k)];
      gnt_idx_s   = gnt_hit_s ? rr_index(ptr_q, k) : gnt_idx_s;
      gnt_found_s = gnt_found_s | gnt_hit_s;
    end
  end

  // Accept decode; held at zero while reset is asserted.
  always_comb begin
    req_ready_s = '0;
    if (rst_n && (state_q == ST_IDLE) && gnt_found_s) begin
      req_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Operand/opcode mux for the granted requester.
  always_comb begin
    gnt_op_s = '0;
    gnt_a_s  = '0;
    gnt_b_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_op_s = (gnt_idx_s == IDW'(i)) ? req_op[2*i +: 2] : gnt_op_s;
      gnt_a_s  = (gnt_idx_s == IDW'(i)) ? req_a[W*i +: W]  : gnt_a_s;
      gnt_b_s  = (gnt_idx_s == IDW'(i)) ? req_b[W*i +: W]  : gnt_b_s;
    end
  end

  // Shared datapath. Operands are sign-extended to 2W first, so add/sub are
  // exact and the low 2W bits of the product are the full signed product.
  always_comb begin
    a_ext_s   = {{W{a_q[W-1]}}, a_q};
    b_ext_s   = {{W{b_q[W-1]}}, b_q};
    res_s     = '0;
    res_err_s = 1'b0;
    case (op_q)
      OP_ADD:  res_s = a_ext_s + b_ext_s;
      OP_SUB:  res_s = a_ext_s - b_ext_s;
      OP_MUL:  res_s = a_ext_s * b_ext_s;
      default: begin
        res_s     = '0;
        res_err_s = 1'b1;
      end
    endcase
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found_s) begin
          state_d = ST_EXEC;
          op_d    = gnt_op_s;
          a_d     = gnt_a_s;
          b_d     = gnt_b_s;
          id_d    = gnt_idx_s;
          ptr_d   = rr_index(gnt_idx_s, 1);
          cnt_d   = (gnt_op_s == OP_MUL) ? CW'(MUL_LAT - 1) : '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = res_s;
          rsp_err_d   = res_err_s;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        // Return to IDLE only; the next grant is decoded from IDLE next cycle.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_arith_sched.sv
// tb_arith_sched: self-checking bench for arith_sched. A negedge monitor keeps
// its own round-robin/busy model, predicts req_ready every cycle, pushes the
// expected response on each handshake and compares it against the response
// channel (value, tag, latency, stability under backpressure).
module tb_arith_sched;
  localparam int NREQ    = 2;
  localparam int W       = 17;
  localparam int MUL_LAT = 2;
  localparam int IDW     = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_a;
  logic [W*NREQ-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_data;
  logic                rsp_err;

  arith_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [33:0]    data;
    logic           err;
    int             lat;
    int             hs;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt [NREQ];
  int   m_ptr = 0;
  bit   m_busy = 1'b0;
  bit   prev_valid = 1'b0;
  bit   m_hit;
  int   m_idx;
  int   m_gid;
  logic [NREQ-1:0] exp_rdy;
  exp_t e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void calc(input logic [1:0] op, input logic [16:0] a, input logic [16:0] b,
                               output logic [33:0] d, output logic er);
    longint sa, sb, r;
    sa = {{47{a[16]}}, a};
    sb = {{47{b[16]}}, b};
    er = 1'b0;
    case (op)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sa * sb;
      default: begin r = 0; er = 1'b1; end
    endcase
    d = r[33:0];
  endfunction

  always @(posedge clk) cyc++;

  // Reference model and scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_busy     = 1'b0;
      m_ptr      = 0;
      prev_valid = 1'b0;
    end else begin
      exp_rdy = '0;
      m_hit   = 1'b0;
      m_gid   = 0;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          m_idx = (m_ptr + k) % NREQ;
          if (!m_hit && req_valid[m_idx]) begin
            m_hit = 1'b1;
            m_gid = m_idx;
          end
        end
      end
      if (m_hit) exp_rdy[m_gid] = 1'b1;
      check_eq("req_ready", req_ready, exp_rdy);
      if (m_hit) begin
        e.id  = m_gid[IDW-1:0];
        calc(req_op[2*m_gid +: 2], req_a[W*m_gid +: W], req_b[W*m_gid +: W], e.data, e.err);
        e.lat = (req_op[2*m_gid +: 2] == 2'b10) ? MUL_LAT : 1;
        e.hs  = cyc;
        sb_q.push_back(e);
        m_ptr  = (m_gid + 1) % NREQ;
        m_busy = 1'b1;
        acc_cnt[m_gid]++;
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_rsp", sb_q.size(), 1);
        end else begin
          if (!prev_valid) check_eq("latency", cyc - sb_q[0].hs, sb_q[0].lat + 1);
          check_eq("rsp_id", rsp_id, sb_q[0].id);
          check_eq("rsp_data", rsp_data, sb_q[0].data);
          check_eq("rsp_err", rsp_err, sb_q[0].err);
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic drive(input int i, input logic [1:0] op, input logic [16:0] a, input logic [16:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic wait_hs(input int i);
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("hs_wait", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [16:0] a, input logic [16:0] b);
    drive(i, op, a, b);
    wait_hs(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("drain", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("rsp_wait", ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a0, a1, d0, d1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    foreach (acc_cnt[i]) acc_cnt[i] = 0;

    // Reset state, with requests pending to show req_ready is held low.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_id", rsp_id, 1'b0);
    check_eq("rst_rsp_data", rsp_data, 34'h0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_req_ready", req_ready, 2'b00);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: add with negative operand.
    issue(0, 2'b00, 17'h1FFFB, 17'h00003);
    wait_idle();

    // 2: sub extremes, then full-width multiply.
    issue(1, 2'b01, 17'h10000, 17'h0FFFF);
    wait_idle();
    issue(1, 2'b10, 17'h10000, 17'h10000);
    wait_idle();

    // 3: both requesters continuously valid.
    a0 = acc_cnt[0];
    a1 = acc_cnt[1];
    drive(0, 2'b10, 17'h1FFFD, 17'h00007);
    drive(1, 2'b00, 17'h00064, 17'h1FF38);
    repeat (40) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();
    d0 = acc_cnt[0] - a0;
    d1 = acc_cnt[1] - a1;
    check_eq("rr_both_served", (d0 >= 3) && (d1 >= 3), 1'b1);
    check_eq("rr_balance", (d0 - d1 <= 1) && (d1 - d0 <= 1), 1'b1);

    // 4: backpressure for 5 cycles with another requester waiting.
    rsp_ready = 1'b0;
    issue(0, 2'b01, 17'h00010, 17'h00020);
    drive(1, 2'b10, 17'h0FFFF, 17'h1FFFF);
    wait_rsp_valid();
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_hs(1);
    req_valid[1] = 1'b0;
    wait_idle();

    // 5: reserved opcode from req 1, then pointer must favour req 0.
    issue(1, 2'b11, 17'h00123, 17'h00456);
    wait_idle();
    drive(0, 2'b00, 17'h00001, 17'h00002);
    drive(1, 2'b00, 17'h00003, 17'h00004);
    wait_hs(0);
    req_valid[0] = 1'b0;
    wait_hs(1);
    req_valid[1] = 1'b0;
    wait_idle();

    // 6a: reset in the middle of a multiply.
    issue(0, 2'b10, 17'h00003, 17'h1FFFF);
    #1;
    rst_n = 1'b0;
    drive(1, 2'b00, 17'h00005, 17'h00006);
    #1;
    check_eq("rst_exec_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_exec_req_ready", req_ready, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 2'b01, 17'h00009, 17'h00001);
    wait_hs(0);
    req_valid[0] = 1'b0;
    wait_hs(1);
    req_valid[1] = 1'b0;
    wait_idle();

    // 6b: reset while a response is held under backpressure.
    rsp_ready = 1'b0;
    issue(1, 2'b00, 17'h00011, 17'h00022);
    wait_rsp_valid();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_resp_valid", rsp_valid, 1'b0);
    check_eq("rst_resp_data", rsp_data, 34'h0);
    check_eq("rst_resp_id", rsp_id, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    issue(1, 2'b01, 17'h00000, 17'h00001);
    wait_idle();

    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_sched.md
Name: arith_sched

Overview:
Scheduler that shares a single signed add/subtract/multiply datapath between NREQ requesters. The datapath operates on 17-bit two's-complement operands. Requests are granted round-robin over valid/ready handshakes. One operation is in flight at a time, with op-dependent latency. Results return on one response channel tagged with the requester ID and are held under backpressure. It sits between client engines and the arithmetic units.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 17, operand width in bits, signed two's complement
MUL_LAT, 2, execute cycles for multiply (>=1); add/sub always take 1
IDW, 1, requester ID width = max(1, clog2(NREQ))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_op  in  2*NREQ  op per requester, slice i = [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 reserved
req_a  in  W*NREQ  operand A per requester, slice i = [W*i+W-1:W*i]
req_b  in  W*NREQ  operand B per requester, same slicing
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  index of the requester that issued the op
rsp_data  out  2*W  signed result, sign-extended to 2W
rsp_err  out  1  1 = reserved opcode, rsp_data = 0

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, round-robin pointer = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, req_ready = 0. An in-flight op is discarded and produces no response.
- FSM states:
  - IDLE -> EXEC on a request handshake.
  - EXEC -> RESP when the latency counter expires.
  - RESP -> IDLE on rsp_valid & rsp_ready.
- IDLE grant:
  - Search from the pointer upward with wrap-around; grant the first i with req_valid[i].
  - req_ready[i] = 1 combinationally only for that i, only in IDLE.
  - If no req_valid is set, req_ready is all 0 and the FSM stays in IDLE.
- Handshake at edge T (req_valid[i] & req_ready[i]):
  - Capture op, a, b and id = i.
  - Pointer <= (i+1) mod NREQ.
  - Load the counter with L-1, where L = 1 for add/sub/reserved and L = MUL_LAT for mul.
- EXEC: the counter decrements each edge. At the edge where the counter is 0, rsp_data/rsp_err/rsp_id are registered, rsp_valid <= 1 and state <= RESP. rsp_valid is first visible after edge T+L.
- Arithmetic:
  - Add: sext18(a) + sext18(b). Sub: sext18(a) - sext18(b). Both are exact (no overflow) and are then sign-extended to 2W.
  - Mul: full signed 2W-bit product, exact.
  - Reserved op: rsp_err = 1, rsp_data = 0, L = 1.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err stay stable until rsp_ready.
  - On the accepting edge, rsp_valid <= 0 and state <= IDLE. rsp_data/rsp_id/rsp_err keep their values.
  - No same-cycle re-grant: the next grant occurs the cycle after return to IDLE. Minimum issue interval is L+2 cycles.
- Requester rules: once req_valid[i] is asserted, op/a/b are held until accepted. A requester may deassert valid before acceptance; the arbiter never grants on stale inputs.
- Input changes on non-granted requesters during EXEC/RESP have no effect.
- rsp_ready held high: response accepted the first cycle rsp_valid is seen.
- All outputs are registered except req_ready, which is decoded from state, pointer and req_valid.

Test Plan:
1. Reset, then req 0 add, a = 17'h1FFFB (-5), b = 3 -> rsp_valid 1 cycle after accept; rsp_id 0, rsp_data 34'h3FFFFFFFE, rsp_err 0.
2. Req 1 sub, a = 17'h10000 (-65536), b = 17'h0FFFF (65535) -> rsp_data 34'h3FFFE0001; mul a = b = 17'h10000 -> rsp_data 34'h100000000, rsp_valid exactly MUL_LAT = 2 cycles after accept.
3. Both requesters valid continuously, rsp_ready = 1 -> grants alternate 0,1,0,1 and rsp_id follows the same order; each requester is accepted once per two ops.
4. rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready all 0, no new grant; raise rsp_ready -> grant issued the following cycle.
5. Reserved op 2'b11 from req 1 -> rsp_err 1, rsp_data 0, 1-cycle latency, pointer advances to 0.
6. Assert rst_n low mid-mul (EXEC) -> rsp_valid 0 immediately (asynchronous); after release, pointer = 0 and no response for the dropped op.
